// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the memory bus shared by the I-cache and
// the D-cache. It forwards the winner's request to the SDRAM burst controller,
// returns grant and burst-window strobes to the owner only, and enforces a
// turnaround gap after every transfer.
module mem_bus_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TURN    = 1
) (
    input  logic          Clk_i,
    input  logic          Reset_i,
    // instruction cache port
    input  logic          IStrobe_i,
    input  logic          IRW_i,
    input  logic [AW-1:0] IAddress_i,
    output logic          IGrant_o,
    output logic          I_TxD_o,
    output logic          I_RxD_o,
    // data cache port
    input  logic          DStrobe_i,
    input  logic          DRW_i,
    input  logic [3:0]    DBE_i,
    input  logic [AW-1:0] DAddress_i,
    output logic          DGrant_o,
    output logic          D_TxD_o,
    output logic          D_RxD_o,
    // SDRAM burst controller
    output logic          SdrReq_o,
    output logic          SdrRW_o,
    output logic [AW-1:0] SdrAddr_o,
    output logic [3:0]    SdrBE_o,
    input  logic          SdrAck_i,
    input  logic          SdrTxD_i,
    input  logic          SdrRxD_i,
    input  logic          SdrDone_i,
    // status
    output logic          Owner_o,
    output logic          BusErr_o
);

    localparam int unsigned CW  = 8;
    localparam int unsigned TCW = (TURN > 1) ? $clog2(TURN) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    logic [1:0]    state_q,      state_d;
    logic          owner_q,      owner_d;
    logic          last_owner_q, last_owner_d;
    logic          igrant_q,     igrant_d;
    logic          dgrant_q,     dgrant_d;
    logic          sdr_req_q,    sdr_req_d;
    logic          sdr_rw_q,     sdr_rw_d;
    logic [AW-1:0] sdr_addr_q,   sdr_addr_d;
    logic [3:0]    sdr_be_q,     sdr_be_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [TCW-1:0] turn_cnt_q,  turn_cnt_d;
    logic          bus_err_q,    bus_err_d;

    logic          win_c;
    logic          owner_strobe_c;
    logic          timeout_hit_c;
    logic          enter_turn_c;
    logic [CW-1:0] cnt_inc_c;

    // State and latch registers; everything clears on reset.
    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            igrant_q     <= 1'b0;
            dgrant_q     <= 1'b0;
            sdr_req_q    <= 1'b0;
            sdr_rw_q     <= 1'b0;
            sdr_addr_q   <= '0;
            sdr_be_q     <= 4'h0;
            cnt_q        <= '0;
            turn_cnt_q   <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            igrant_q     <= igrant_d;
            dgrant_q     <= dgrant_d;
            sdr_req_q    <= sdr_req_d;
            sdr_rw_q     <= sdr_rw_d;
            sdr_addr_q   <= sdr_addr_d;
            sdr_be_q     <= sdr_be_d;
            cnt_q        <= cnt_d;
            turn_cnt_q   <= turn_cnt_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Arbitration, transfer sequencing, timeout and turnaround.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_owner_d   = last_owner_q;
        igrant_d       = igrant_q;
        dgrant_d       = dgrant_q;
        sdr_req_d      = sdr_req_q;
        sdr_rw_d       = sdr_rw_q;
        sdr_addr_d     = sdr_addr_q;
        sdr_be_d       = sdr_be_q;
        cnt_d          = cnt_q;
        turn_cnt_d     = turn_cnt_q;
        bus_err_d      = 1'b0;
        enter_turn_c   = 1'b0;
        win_c          = 1'b0;

        owner_strobe_c = owner_q ? DStrobe_i : IStrobe_i;
        // saturating increment: the counter never wraps back to zero
        cnt_inc_c      = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
        timeout_hit_c  = (cnt_q >= CW'(TIMEOUT - 1));

        case (state_q)
            ST_IDLE: begin
                if (IStrobe_i || DStrobe_i) begin
                    // lone requester wins; on contention the last owner yields
                    win_c      = (IStrobe_i && DStrobe_i) ? !last_owner_q : DStrobe_i;
                    state_d    = ST_REQ;
                    owner_d    = win_c;
                    igrant_d   = !win_c;
                    dgrant_d   = win_c;
                    sdr_req_d  = 1'b1;
                    sdr_rw_d   = win_c ? DRW_i : IRW_i;
                    sdr_addr_d = win_c ? DAddress_i : IAddress_i;
                    sdr_be_d   = win_c ? DBE_i : 4'hF;
                    cnt_d      = '0;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc_c;
                if (SdrAck_i && SdrDone_i) begin
                    enter_turn_c = 1'b1;
                end else if (SdrAck_i) begin
                    state_d   = ST_BURST;
                    sdr_req_d = 1'b0;
                    cnt_d     = '0;
                end else if (!owner_strobe_c) begin
                    enter_turn_c = 1'b1;
                end else if (timeout_hit_c) begin
                    enter_turn_c = 1'b1;
                    bus_err_d    = 1'b1;
                end
            end
            ST_BURST: begin
                // the owner cannot withdraw once the controller has accepted
                cnt_d = cnt_inc_c;
                if (SdrDone_i) begin
                    enter_turn_c = 1'b1;
                end else if (timeout_hit_c) begin
                    enter_turn_c = 1'b1;
                    bus_err_d    = 1'b1;
                end
            end
            ST_TURN: begin
                turn_cnt_d = turn_cnt_q + TCW'(1);
                if (turn_cnt_q == TCW'(TURN - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_turn_c) begin
            state_d      = ST_TURN;
            igrant_d     = 1'b0;
            dgrant_d     = 1'b0;
            sdr_req_d    = 1'b0;
            last_owner_d = owner_q;
            turn_cnt_d   = '0;
        end
    end

    // Burst windows reach the owning cache only, and only during the burst.
    always_comb begin
        I_TxD_o = (state_q == ST_BURST) && !owner_q && SdrTxD_i;
        I_RxD_o = (state_q == ST_BURST) && !owner_q && SdrRxD_i;
        D_TxD_o = (state_q == ST_BURST) &&  owner_q && SdrTxD_i;
        D_RxD_o = (state_q == ST_BURST) &&  owner_q && SdrRxD_i;
    end

    assign IGrant_o  = igrant_q;
    assign DGrant_o  = dgrant_q;
    assign SdrReq_o  = sdr_req_q;
    assign SdrRW_o   = sdr_rw_q;
    assign SdrAddr_o = sdr_addr_q;
    assign SdrBE_o   = sdr_be_q;
    assign Owner_o   = owner_q;
    assign BusErr_o  = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized transactions against a
// transaction-level model of the arbiter (round-robin winner, latched request,
// owner-only burst windows, timeout and turnaround gap).
module tb_mem_bus_arbiter;

    localparam int unsigned AW      = 32;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned TURN    = 1;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          IStrobe, IRW;
    logic [AW-1:0] IAddress;
    logic          IGrant, I_TxD, I_RxD;
    logic          DStrobe, DRW;
    logic [3:0]    DBE;
    logic [AW-1:0] DAddress;
    logic          DGrant, D_TxD, D_RxD;
    logic          SdrReq, SdrRW;
    logic [AW-1:0] SdrAddr;
    logic [3:0]    SdrBE;
    logic          SdrAck, SdrTxD, SdrRxD, SdrDone;
    logic          Owner, BusErr;

    int checks = 0;
    int errors = 0;

    // model state
    bit          last_owner;
    bit          pend_i, pend_d;
    bit          rw_i, rw_d;
    logic [31:0] addr_i, addr_d;
    logic [3:0]  be_d;

    mem_bus_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT), .TURN(TURN)) dut (
        .Clk_i(Clk), .Reset_i(Reset),
        .IStrobe_i(IStrobe), .IRW_i(IRW), .IAddress_i(IAddress),
        .IGrant_o(IGrant), .I_TxD_o(I_TxD), .I_RxD_o(I_RxD),
        .DStrobe_i(DStrobe), .DRW_i(DRW), .DBE_i(DBE), .DAddress_i(DAddress),
        .DGrant_o(DGrant), .D_TxD_o(D_TxD), .D_RxD_o(D_RxD),
        .SdrReq_o(SdrReq), .SdrRW_o(SdrRW), .SdrAddr_o(SdrAddr), .SdrBE_o(SdrBE),
        .SdrAck_i(SdrAck), .SdrTxD_i(SdrTxD), .SdrRxD_i(SdrRxD), .SdrDone_i(SdrDone),
        .Owner_o(Owner), .BusErr_o(BusErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_req();
        IStrobe  = pend_i; IRW = rw_i; IAddress = addr_i;
        DStrobe  = pend_d; DRW = rw_d; DAddress = addr_d; DBE = be_d;
    endtask

    task automatic new_req(input bit is_d);
        if (is_d) begin
            pend_d = 1'b1; addr_d = $urandom;
            rw_d = 1'($urandom_range(0, 1)); be_d = 4'($urandom_range(0, 15));
        end else begin
            pend_i = 1'b1; addr_i = $urandom;
            rw_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_igrant"}, IGrant, 1'b0);
        chk1({tag, "_dgrant"}, DGrant, 1'b0);
        chk1({tag, "_sdrreq"}, SdrReq, 1'b0);
    endtask

    // One complete transfer for the model's winner, ending in IDLE after the gap.
    task automatic serve(input int ack_dly, input int blen);
        bit          w, tx, rx;
        bit          erw;
        logic [31:0] ea;
        logic [3:0]  ebe;
        w   = (pend_i && pend_d) ? !last_owner : pend_d;
        ea  = w ? addr_d : addr_i;
        erw = w ? rw_d : rw_i;
        ebe = w ? be_d : 4'hF;
        drive_req();
        step();
        chk1("grant_i", IGrant, !w);
        chk1("grant_d", DGrant, w);
        chk1("owner", Owner, w);
        chk1("req_up", SdrReq, 1'b1);
        chk32("addr", SdrAddr, ea);
        chk1("rw", SdrRW, erw);
        chk32("be", 32'(SdrBE), 32'(ebe));
        // winner's inputs change under a held strobe; latches must not follow
        if (w) begin DAddress = $urandom; DRW = ~DRW; DBE = ~DBE; end
        else begin IAddress = $urandom; IRW = ~IRW; end
        for (int k = 0; k < ack_dly; k++) begin
            step();
            chk1("req_hold", SdrReq, 1'b1);
            chk1("req_grant", w ? DGrant : IGrant, 1'b1);
            chk1("req_noerr", BusErr, 1'b0);
        end
        SdrAck = 1'b1; SdrDone = (blen == 0);
        step();
        SdrAck = 1'b0; SdrDone = 1'b0;
        if (blen > 0) begin
            chk1("burst_req", SdrReq, 1'b0);
            chk1("burst_grant", w ? DGrant : IGrant, 1'b1);
            for (int b = 0; b < blen; b++) begin
                tx = 1'($urandom_range(0, 1));
                rx = 1'($urandom_range(0, 1));
                SdrTxD = tx; SdrRxD = rx; SdrDone = (b == blen - 1);
                if (b == 0 && blen > 1) begin
                    if (w) DStrobe = 1'b0; else IStrobe = 1'b0;
                end
                #1;
                chk1("txd_own", w ? D_TxD : I_TxD, tx);
                chk1("rxd_own", w ? D_RxD : I_RxD, rx);
                chk1("txd_other", w ? I_TxD : D_TxD, 1'b0);
                chk1("rxd_other", w ? I_RxD : D_RxD, 1'b0);
                step();
            end
            SdrTxD = 1'b0; SdrRxD = 1'b0; SdrDone = 1'b0;
        end
        chk_quiet("turn");
        chk1("turn_noerr", BusErr, 1'b0);
        chk32("turn_addr_held", SdrAddr, ea);
        chk1("turn_rw_held", SdrRW, erw);
        last_owner = w;
        if (w) pend_d = 1'b0; else pend_i = 1'b0;
        drive_req();
        for (int t = 0; t < int'(TURN); t++) begin
            step();
            chk1("gap_igrant", IGrant, 1'b0);
            chk1("gap_dgrant", DGrant, 1'b0);
        end
    endtask

    // D request that never completes: BusErr exactly TIMEOUT cycles after entry.
    task automatic timeout_case(input bit with_ack);
        pend_i = 1'b0;
        new_req(1'b1);
        drive_req();
        step();
        chk1("to_grant", DGrant, 1'b1);
        if (with_ack) begin
            SdrAck = 1'b1;
            step();
            SdrAck = 1'b0;
            chk1("to_burst_req", SdrReq, 1'b0);
        end
        for (int k = 1; k < int'(TIMEOUT); k++) begin
            step();
            chk1("to_wait_err", BusErr, 1'b0);
            chk1("to_wait_grant", DGrant, 1'b1);
        end
        step();
        chk1("to_err", BusErr, 1'b1);
        chk1("to_grant_drop", DGrant, 1'b0);
        chk1("to_req_drop", SdrReq, 1'b0);
        last_owner = 1'b1;
        pend_d = 1'b0;
        drive_req();
        for (int t = 0; t < int'(TURN); t++) begin
            step();
            chk1("to_err_pulse", BusErr, 1'b0);
        end
    endtask

    initial begin
        Reset = 1'b0;
        pend_i = 0; pend_d = 0; rw_i = 0; rw_d = 0;
        addr_i = 0; addr_d = 0; be_d = 0; last_owner = 0;
        drive_req();
        SdrAck = 0; SdrTxD = 0; SdrRxD = 0; SdrDone = 0;
        #12;
        chk_quiet("rst");
        chk32("rst_addr", SdrAddr, 32'h0);
        chk1("rst_owner", Owner, 1'b0);
        chk1("rst_err", BusErr, 1'b0);
        Reset = 1'b1;
        step();

        // simultaneous requests after reset: D first, then strict alternation
        new_req(1'b0); new_req(1'b1);
        for (int r = 0; r < 4; r++) begin
            serve(1, 2);
            if (!pend_i) new_req(1'b0);
            if (!pend_d) new_req(1'b1);
        end
        pend_i = 0; pend_d = 0; drive_req();
        step();
        chk_quiet("idle");

        // D read burst: ack on the third cycle after grant, four read beats
        pend_d = 1; rw_d = 1; addr_d = 32'h0000_1000; be_d = 4'hF;
        serve(2, 4);

        // I request with ack and done together
        new_req(1'b0);
        serve(0, 0);

        // timeouts waiting for ack, then waiting for done
        timeout_case(1'b0);
        timeout_case(1'b1);

        // D withdraws before ack while I waits
        new_req(1'b1); drive_req();
        step();
        chk1("ab_grant", DGrant, 1'b1);
        new_req(1'b0); drive_req();
        step();
        chk1("ab_req", SdrReq, 1'b1);
        DStrobe = 1'b0;
        step();
        chk_quiet("ab");
        chk1("ab_noerr", BusErr, 1'b0);
        last_owner = 1'b1; pend_d = 1'b0;
        for (int t = 0; t < int'(TURN); t++) begin
            step();
            chk1("ab_gap", IGrant, 1'b0);
        end
        serve(1, 3);

        // reset in the middle of a burst
        new_req(1'b1); drive_req();
        step();
        SdrAck = 1'b1;
        step();
        SdrAck = 1'b0; SdrRxD = 1'b1; SdrTxD = 1'b1;
        #1;
        chk1("mid_rxd", D_RxD, 1'b1);
        Reset = 1'b0;
        #1;
        chk_quiet("mrst");
        chk1("mrst_rxd", D_RxD, 1'b0);
        chk1("mrst_txd", D_TxD, 1'b0);
        chk1("mrst_owner", Owner, 1'b0);
        chk1("mrst_rw", SdrRW, 1'b0);
        chk32("mrst_addr", SdrAddr, 32'h0);
        chk32("mrst_be", 32'(SdrBE), 32'h0);
        SdrRxD = 0; SdrTxD = 0;
        pend_d = 0; pend_i = 0; last_owner = 0; drive_req();
        step();
        Reset = 1'b1;
        step();
        new_req(1'b1);
        serve(0, 2);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!pend_i && !pend_d) begin
                if ($urandom_range(0, 2) == 0) begin
                    step();
                    chk_quiet("rnd_idle");
                end
                case ($urandom_range(0, 2))
                    0: new_req(1'b0);
                    1: new_req(1'b1);
                    default: begin new_req(1'b0); new_req(1'b1); end
                endcase
            end else if ($urandom_range(0, 1) == 1) begin
                if (!pend_i) new_req(1'b0);
                if (!pend_d) new_req(1'b1);
            end
            serve($urandom_range(0, 4), $urandom_range(0, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the synchronous memory bus between the instruction cache (port I) and the data cache (port D), and forwards the winning request to the SDRAM burst controller.
- Returns grant and burst-window strobes (TxD/RxD) to the owning cache only.
- Sits directly downstream of the caches' MStrobe/MRW/MBE/MAddress/MGrant/mSDR_TxD/mSDR_RxD interface.
- Carries no data; MData stays a shared tri-state bus whose drivers are gated by the grant.

Parameters:
- AW, 32, address width.
- TIMEOUT, 255, max cycles waiting for SdrAck (REQ) or SdrDone (BURST) before the transfer is abandoned; 8-bit counter.
- TURN, 1, bus turnaround cycles after every transfer (≥1).

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IStrobe  in  1  I-cache request; held until IGrant falls.
- IRW  in  1  I-cache direction, 1 = read.
- IAddress  in  AW  I-cache halfword address.
- IGrant  out  1  I-cache owns bus.
- I_TxD  out  1  write-burst window to I-cache.
- I_RxD  out  1  read-burst window to I-cache.
- DStrobe  in  1  D-cache request; held until DGrant falls.
- DRW  in  1  D-cache direction, 1 = read.
- DBE  in  4  D-cache byte enables.
- DAddress  in  AW  D-cache halfword address.
- DGrant  out  1  D-cache owns bus.
- D_TxD  out  1  write-burst window to D-cache.
- D_RxD  out  1  read-burst window to D-cache.
- SdrReq  out  1  request to SDRAM controller.
- SdrRW  out  1  latched direction.
- SdrAddr  out  AW  latched address.
- SdrBE  out  4  latched byte enables; 4'hF for I.
- SdrAck  in  1  controller accepted request, 1-cycle pulse.
- SdrTxD  in  1  controller write window.
- SdrRxD  in  1  controller read window.
- SdrDone  in  1  last burst beat, 1-cycle pulse.
- Owner  out  1  0 = I, 1 = D; valid while a grant is high.
- BusErr  out  1  1-cycle pulse on timeout.

Behaviour:
- Reset low: state = IDLE. All outputs 0, including Sdr* latches. LastOwner = I, so D wins the first contention. Counters are cleared.
- States:
  - IDLE: no grant. Any strobe causes arbitration.
    - Only one strobe high: that port wins.
    - Both high: winner = !LastOwner (round robin).
    - Next cycle: enter REQ. Grant, Owner and SdrReq are registered high; SdrRW/SdrAddr/SdrBE are latched from the winner in the same edge.
  - REQ: SdrReq held high, timeout counter increments.
    - SdrAck=1: go to BURST, SdrReq low next cycle.
    - SdrAck and SdrDone both 1 in the same cycle: go straight to TURN.
    - Owner strobe drops before ack: abort, go to TURN with SdrReq low, no BusErr.
  - BURST: SdrTxD/SdrRxD pass combinationally to the owner's TxD/RxD. The non-owner's TxD/RxD is 0.
    - Owner strobe dropping here is ignored; the burst always completes.
    - SdrDone=1: go to TURN.
  - TURN: grants are low from entry. Stay TURN cycles, then go to IDLE. LastOwner is updated at TURN entry.
- Grant behaviour:
  - Grant rises 1 cycle after strobe seen in IDLE; minimum request-to-grant latency is 1 cycle.
  - Grant falls on the edge entering TURN.
  - IGrant and DGrant are never both 1.
- Timeout:
  - Counter resets on entry to REQ and on entry to BURST.
  - Counter reaching TIMEOUT in REQ or BURST: BusErr pulses 1 cycle, SdrReq drops, go to TURN.
  - Counter saturates; it never wraps.
- Latches: SdrRW/SdrAddr/SdrBE hold their value until the next grant. Input changes after grant do not affect them.
- Strobe in TURN: not sampled until IDLE. A requester held off for TURN+1 cycles still gets served in round-robin order.
- Reset asserted mid-BURST: immediate return to reset values. The controller must discard the transfer.

Test Plan:
1. DStrobe=1, DRW=1, DAddress=0x0000_1000, DBE=4'hF.
   - DGrant=1 and SdrReq=1 next cycle, SdrAddr=0x1000, SdrRW=1.
   - Ack at cycle +3, 4-cycle SdrRxD, Done: D_RxD mirrors SdrRxD, I_RxD=0.
   - DGrant low on the cycle after Done, IDLE after TURN.
2. IStrobe and DStrobe rise together after reset:
   - D is served first, then I, with TURN gap.
   - Repeat both held: order alternates D, I, D, I.
3. I read with SdrAck and SdrDone in the same cycle: REQ goes straight to TURN, IGrant high exactly 1 cycle, no BusErr.
4. DStrobe with SdrAck never asserted:
   - BusErr pulses once at cycle TIMEOUT (255) after REQ entry, then DGrant=0 and SdrReq=0.
   - Repeat with Ack but no Done: BusErr at 255 cycles after BURST entry.
5. Abort: DStrobe dropped 2 cycles into REQ before Ack → SdrReq=0 next cycle, TURN, no BusErr. IStrobe pending → IGrant after TURN.
6. Reset pulled low during BURST: all outputs 0 asynchronously. After release, DStrobe is granted normally with SdrAddr taken from the new request.
